// File: rtl/poly1305_acc_mul.sv
// poly1305_acc_mul: (acc_in + padded block) * r via four 32-bit limb passes; POLY1305_CLAMP_EN clamps r on load.
module poly1305_acc_mul (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [127:0] block_in,
  input  logic [4:0]   block_len,
  input  logic [127:0] r_key,
  input  logic [129:0] acc_in,
  output logic [257:0] product_out,
  output logic         busy,
  output logic         done
);
  typedef enum logic [1:0] {IDLE, LOAD, MUL, FIN} state_t;
  state_t state, state_nx;
  logic [127:0] blk_q, r_in_q, r_q, r_load;
  logic [4:0]   len_q, n;
  logic [129:0] acc_q;
  logic [130:0] sum_q;
  logic [257:0] partial, term;
  logic [128:0] one_hot, padded;
  logic [162:0] pp;
  logic [1:0]   k;
  always_comb begin
    n = (len_q == 5'd0 || len_q > 5'd16) ? 5'd16 : len_q;
    one_hot = 129'd1 << {n, 3'b000};
    padded = ({1'b0, blk_q} & (one_hot - 129'd1)) | one_hot;
    pp = {32'd0, sum_q} * {131'd0, r_q[{k, 5'b00000} +: 32]};
    term = {95'd0, pp} << {k, 5'b00000};
`ifdef POLY1305_CLAMP_EN
    r_load = r_in_q & 128'h0ffffffc0ffffffc0ffffffc0fffffff;
`else
    r_load = r_in_q;
`endif
    state_nx = (state == IDLE) ? (start ? LOAD : IDLE) :
               (state == LOAD) ? MUL :
               (state == MUL)  ? ((k == 2'd3) ? FIN : MUL) : IDLE;
  end
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      {blk_q, r_in_q, len_q, acc_q} <= '0;
      {sum_q, r_q, partial, k} <= '0;
      product_out <= '0;
      done <= 1'b0;
    end else begin
      done <= state == FIN;
      if (state == IDLE && start) {blk_q, r_in_q, len_q, acc_q} <= {block_in, r_key, block_len, acc_in};
      if (state == LOAD) begin
        sum_q <= {1'b0, acc_q} + {2'b00, padded};
        r_q <= r_load;
        k <= 2'd0;
        partial <= '0;
      end
      if (state == MUL) begin
        partial <= partial + term;
        k <= k + 2'd1;
      end
      if (state == FIN) product_out <= partial;
    end
endmodule

// File: tb/tb_poly1305_acc_mul.sv
// tb_poly1305_acc_mul: randomized scoreboard bench against a big-integer reference of the accumulate-multiply.
module tb_poly1305_acc_mul;
  logic clk = 0, reset_n = 1, start = 0;
  logic [127:0] block_in = 0, r_key = 0;
  logic [4:0] block_len = 0;
  logic [129:0] acc_in = 0;
  logic [257:0] product_out;
  logic busy, done;
  localparam logic [127:0] CLAMP = 128'h0ffffffc0ffffffc0ffffffc0fffffff;
  typedef struct {logic [257:0] v; int due; bit top0;} exp_t;
  exp_t q[$];
  exp_t e;
  int cyc = 0, cnt = 0, errors = 0, checks = 0;
  logic [257:0] last = 0;

  poly1305_acc_mul dut (.clk(clk), .reset_n(reset_n), .start(start), .block_in(block_in),
    .block_len(block_len), .r_key(r_key), .acc_in(acc_in), .product_out(product_out),
    .busy(busy), .done(done));

  always #5 clk = ~clk;

  function automatic logic [127:0] eff_r(input logic [127:0] r);
`ifdef POLY1305_CLAMP_EN
    return r & CLAMP;
`else
    return r;
`endif
  endfunction

  function automatic logic [257:0] ref_prod(input logic [129:0] a, input logic [127:0] b,
                                            input logic [4:0] l, input logic [127:0] r);
    logic [511:0] p, s;
    int n;
    n = (l == 0 || l > 16) ? 16 : int'(l);
    p = '0;
    for (int i = 0; i < n; i++) p[8*i +: 8] = b[8*i +: 8];
    p[8*n] = 1'b1;
    s = ({382'd0, a} + p) * {384'd0, eff_r(r)};
    return s[257:0];
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input string nm, input logic [257:0] got, input logic [257:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, want);
    end
  endtask

  // Reference timing: busy for six edges after an accepted start; starts seen while busy are dropped.
  always @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      q.delete();
      cnt = 0;
    end else begin
      cyc++;
      if (start && cnt == 0) begin
        q.push_back('{ref_prod(acc_in, block_in, block_len, r_key), cyc + 6,
                      (eff_r(r_key) & ~CLAMP) == 0});
        cnt = 6;
      end else if (cnt > 0) cnt--;
    end

  always @(negedge clk)
    if (!reset_n) last = 0;
    else begin
      chk("busy", busy, cnt != 0);
      if (done) begin
        if (q.size() == 0) chk("done_unexpected", done, 0);
        else begin
          e = q.pop_front();
          chk("done_cycle", cyc, e.due);
          chk("product", product_out, e.v);
          if (e.top0) chk("product_top", product_out[257:255], 0);
          last = e.v;
        end
      end else if (q.size() > 0 && q[0].due == cyc) begin
        chk("done_missing", done, 1);
        void'(q.pop_front());
      end
      chk("product_hold", product_out, last);
    end

  task automatic pulse(input logic [129:0] a, input logic [127:0] b, input logic [4:0] l,
                       input logic [127:0] r);
    acc_in = a; block_in = b; block_len = l; r_key = r; start = 1;
    @(negedge clk);
    start = 0;
    acc_in = {2'($urandom), rnd128()}; block_in = rnd128(); block_len = 5'($urandom); r_key = rnd128();
  endtask

  task automatic reset_checks();
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_product", product_out, 0);
  endtask

  initial begin
    #1 reset_n = 0;
    reset_checks();
    @(posedge clk); #2 reset_n = 1;
    @(negedge clk);
    pulse(0, 0, 16, 1); repeat (8) @(negedge clk);
    pulse(0, 128'hAB, 1, 2); repeat (8) @(negedge clk);
`ifdef POLY1305_CLAMP_EN
    pulse(0, 0, 16, '1); repeat (8) @(negedge clk);
    pulse('1, '1, 16, '1); repeat (8) @(negedge clk);
`else
    pulse('1, '1, 16, CLAMP); repeat (8) @(negedge clk);
`endif
    pulse({2'($urandom), rnd128()}, rnd128(), 5'd7, rnd128() & CLAMP);
    @(negedge clk);
    pulse({2'($urandom), rnd128()}, rnd128(), 5'd3, rnd128());
    repeat (8) @(negedge clk);
    pulse({2'($urandom), rnd128()}, rnd128(), 5'd0, rnd128());
    repeat (6) @(negedge clk);
    pulse({2'($urandom), rnd128()}, rnd128(), 5'd20, rnd128() & CLAMP);
    repeat (8) @(negedge clk);
    pulse({2'($urandom), rnd128()}, rnd128(), 5'd16, rnd128());
    @(posedge clk); #2 reset_n = 0;
    reset_checks();
    @(posedge clk); #2 reset_n = 1;
    repeat (10) @(negedge clk);
    pulse({2'($urandom), rnd128()}, rnd128(), 5'd9, rnd128() & CLAMP);
    repeat (8) @(negedge clk);
    for (int i = 0; i < 30; i++) begin
      pulse({2'($urandom), rnd128()}, rnd128(), 5'($urandom_range(0, 31)),
            ($urandom % 2) ? rnd128() : rnd128() & CLAMP);
      repeat ($urandom_range(0, 8)) @(negedge clk);
    end
    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d results outstanding, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
